// File: rtl/ara_multi_inval_filter_pkg.sv
// ara_multi_inval_filter_pkg: AXI channel types and constants shared by the invalidation filter.
// Revision: 1.0
`default_nettype none

package ara_multi_inval_filter_pkg;

  localparam int unsigned AxiAddrWidth = 64;
  localparam int unsigned AxiDataWidth = 64;
  localparam int unsigned AxiIdWidth   = 4;
  localparam int unsigned MaxNrHarts   = 8;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef logic [MaxNrHarts-1:0] hart_mask_t;

  typedef struct packed {
    logic [AxiIdWidth-1:0]   id;
    logic [AxiAddrWidth-1:0] addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
  } aw_chan_t;

  typedef aw_chan_t ar_chan_t;

  typedef struct packed {
    logic [AxiDataWidth-1:0]   data;
    logic [AxiDataWidth/8-1:0] strb;
    logic                      last;
  } w_chan_t;

  typedef struct packed {
    logic [AxiIdWidth-1:0] id;
    logic [1:0]            resp;
  } b_chan_t;

  typedef struct packed {
    logic [AxiIdWidth-1:0]   id;
    logic [AxiDataWidth-1:0] data;
    logic [1:0]              resp;
    logic                    last;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    b_chan_t b;
    logic    b_valid;
    r_chan_t r;
    logic    r_valid;
  } resp_t;

endpackage

`default_nettype wire

// File: rtl/ara_multi_inval_filter_if.sv
// ara_multi_inval_filter_if: AXI request/response bundle with master and slave views.
// Revision: 1.0
`default_nettype none

interface ara_multi_inval_filter_if;
  import ara_multi_inval_filter_pkg::*;

  req_t  req;
  resp_t resp;

  modport mst (output req, input resp);
  modport slv (input req, output resp);
endinterface

`default_nettype wire

// File: rtl/ara_multi_inval_filter_fifo.sv
// ara_multi_inval_filter_fifo: pending-AW queue; push is accepted while full if a pop happens too.
// Revision: 1.0
`default_nettype none

module ara_multi_inval_filter_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4
) (
  input  wire logic                  clk_i,
  input  wire logic                  rst_ni,
  input  wire logic                  push_i,
  input  wire logic [DATA_WIDTH-1:0] data_i,
  input  wire logic                  pop_i,
  output logic      [DATA_WIDTH-1:0] data_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0]      rd_ptr_q, wr_ptr_q;
  logic [PTR_W:0]        cnt_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  w_push, w_pop;

  assign full_o  = (cnt_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign w_pop   = pop_i & ~empty_o;
  assign w_push  = push_i & (~full_o | w_pop);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (w_pop)
        rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
      if (w_push)
        wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
      if (w_push && !w_pop)
        cnt_q <= cnt_q + 1'b1;
      else if (w_pop && !w_push)
        cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push)
      mem_q[wr_ptr_q] <= data_i;
  end

endmodule

`default_nettype wire

// File: rtl/ara_multi_inval_filter.sv
// ara_multi_inval_filter: per-line L1 invalidation broadcast for Ara writes, B held until all harts ack.
// Revision: 1.0
`default_nettype none

module ara_multi_inval_filter
  import ara_multi_inval_filter_pkg::*;
#(
  parameter int unsigned NrHarts     = 2,
  parameter int unsigned MaxTxns     = 4,
  parameter int unsigned AddrWidth   = AxiAddrWidth,
  parameter int unsigned L1LineWidth = 16
) (
  input  wire logic                 clk_i,
  input  wire logic                 rst_ni,
  input  wire logic [NrHarts-1:0]   en_i,
  ara_multi_inval_filter_if.slv     slv,
  ara_multi_inval_filter_if.mst     mst,
  output logic      [AddrWidth-1:0] inval_addr_o,
  output logic      [NrHarts-1:0]   inval_valid_o,
  input  wire logic [NrHarts-1:0]   inval_ready_i
);

  typedef enum logic [0:0] {IDLE = 1'b0, ISSUE = 1'b1} state_e;

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
    logic [NrHarts-1:0]   mask;
  } entry_t;

  localparam logic [AddrWidth-1:0] LINE_MASK = ~(AddrWidth'(L1LineWidth) - AddrWidth'(1));

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] cur_line_q, cur_line_d, last_line_q, last_line_d;
  logic [NrHarts-1:0]   mask_q, mask_d, acked_q, acked_d;

  entry_t               w_entry, w_head;
  logic                 w_fifo_full, w_fifo_empty, w_pop, w_push, w_full, w_quiet, w_en;
  logic [NrHarts-1:0]   w_hs;
  logic [AddrWidth-1:0] w_bytes, w_first, w_last;

  assign w_en    = |en_i;
  assign w_pop   = (state_q == IDLE) & ~w_fifo_empty;
  // A slot freed by this cycle's pop can be refilled in the same cycle.
  assign w_full  = w_fifo_full & ~w_pop;
  assign w_push  = w_en & slv.req.aw_valid & mst.resp.aw_ready & ~w_full;
  assign w_quiet = w_fifo_empty & (state_q == IDLE);
  assign w_hs    = inval_valid_o & inval_ready_i;

  assign w_entry = '{addr:  slv.req.aw.addr[AddrWidth-1:0],
                     len:   slv.req.aw.len,
                     size:  slv.req.aw.size,
                     burst: slv.req.aw.burst,
                     mask:  en_i};

  always_comb begin
    mst.req  = slv.req;
    slv.resp = mst.resp;
    if (w_en) begin
      mst.req.aw_valid  = slv.req.aw_valid & ~w_full;
      slv.resp.aw_ready = mst.resp.aw_ready & ~w_full;
    end
    slv.resp.b_valid = mst.resp.b_valid & w_quiet;
    mst.req.b_ready  = slv.req.b_ready & w_quiet;
  end

  ara_multi_inval_filter_fifo #(
    .DATA_WIDTH (AddrWidth + 8 + 3 + 2 + NrHarts),
    .DEPTH      (MaxTxns)
  ) u_aw_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_push),
    .data_i  (w_entry),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty)
  );

  // Byte range touched by the queue head; reserved burst code behaves as INCR.
  always_comb begin
    w_bytes = (AddrWidth'(w_head.len) + AddrWidth'(1)) << w_head.size;
    w_first = w_head.addr;
    w_last  = w_head.addr + w_bytes - AddrWidth'(1);
    case (w_head.burst)
      BURST_FIXED: w_last = w_head.addr + (AddrWidth'(1) << w_head.size) - AddrWidth'(1);
      BURST_WRAP: begin
        w_first = w_head.addr & ~(w_bytes - AddrWidth'(1));
        w_last  = w_first + w_bytes - AddrWidth'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cur_line_q  <= '0;
      last_line_q <= '0;
      mask_q      <= '0;
      acked_q     <= '0;
    end else begin
      state_q     <= state_d;
      cur_line_q  <= cur_line_d;
      last_line_q <= last_line_d;
      mask_q      <= mask_d;
      acked_q     <= acked_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_line_d  = cur_line_q;
    last_line_d = last_line_q;
    mask_d      = mask_q;
    acked_d     = acked_q;
    unique case (state_q)
      IDLE: begin
        if (!w_fifo_empty) begin
          cur_line_d  = w_first & LINE_MASK;
          last_line_d = w_last & LINE_MASK;
          mask_d      = w_head.mask;
          acked_d     = '0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (((acked_q | w_hs) & mask_q) == mask_q) begin
          if (cur_line_q == last_line_q) begin
            state_d = IDLE;
          end else begin
            cur_line_d = cur_line_q + AddrWidth'(L1LineWidth);
            acked_d    = '0;
          end
        end else begin
          acked_d = acked_q | w_hs;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    inval_addr_o  = cur_line_q;
    inval_valid_o = (state_q == ISSUE) ? (mask_q & ~acked_q) : '0;
  end

endmodule

`default_nettype wire
